// File: rtl/pc_pkg.sv
// pc_pkg: shared types and default vectors for the program-counter sequencer.
package pc_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;
  typedef enum logic [2:0] {SEL_EXC, SEL_ERET, SEL_JR, SEL_J, SEL_BR, SEL_SEQ} sel_t;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0040_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: prioritised next-PC select with target arithmetic and misalignment trap.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter int ALIGN_BITS = 2
) (
  input  logic            eff_exc,
  input  logic            eret,
  input  logic            jr,
  input  logic            jump,
  input  logic            br_taken,
  input  logic [25:0]     instr_idx,
  input  logic [XLEN-1:0] ext,
  input  logic [XLEN-1:0] r1,
  input  logic [XLEN-1:0] epc,
  input  logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);
  sel_t sel;
  logic [XLEN-1:0] raw;
  always_comb begin
    sel = eff_exc ? SEL_EXC : eret ? SEL_ERET : jr ? SEL_JR : jump ? SEL_J : br_taken ? SEL_BR : SEL_SEQ;
    target = (sel == SEL_ERET) ? epc : r1;
    // only register-sourced targets can be misaligned; immediates are word-scaled
    misaligned = (sel == SEL_ERET || sel == SEL_JR) && |target[ALIGN_BITS-1:0];
    raw = (sel == SEL_EXC) ? EXC_VECTOR :
          (sel == SEL_ERET || sel == SEL_JR) ? target :
          (sel == SEL_J) ? {pc_plus4[XLEN-1:28], instr_idx, 2'b00} :
          (sel == SEL_BR) ? pc_plus4 + (ext << 2) : pc_plus4;
    next_pc = misaligned ? EXC_VECTOR : raw;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register with valid/ready handshake, sticky exception and fetch counter.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [XLEN-1:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter int ALIGN_BITS = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             fetch_valid,
  input  logic             fetch_ready,
  input  logic             stall,
  input  logic             HasExp,
  input  logic             IsEret,
  input  logic             IsCOP0,
  input  logic             IsJR,
  input  logic             Jump,
  input  logic             Branch,
  input  logic             BneOrBeq,
  input  logic             Equal,
  input  logic [XLEN-1:0]  Instr,
  input  logic [XLEN-1:0]  ExtendInst,
  input  logic [XLEN-1:0]  RegfileR1,
  input  logic [XLEN-1:0]  EPC,
  output logic [XLEN-1:0]  PCOut,
  output logic [XLEN-1:0]  PCPlus4,
  output logic             AddrExc,
  output logic [XLEN-1:0]  BadVAddr,
  output logic [XLEN-1:0]  ExcPC,
  output logic             Holding,
  output logic [CNT_W-1:0] FetchCount
);
  state_t state;
  logic exc_pending, eff_exc, fire, misaligned;
  logic [XLEN-1:0] next_pc, target;
  logic unused_instr_hi;
  assign unused_instr_hi = ^Instr[XLEN-1:26];
  assign fetch_valid = state != BOOT;
  assign Holding = state == HOLD;
  assign PCPlus4 = PCOut + XLEN'(4);
  assign fire = fetch_valid & fetch_ready & ~stall;
  assign eff_exc = HasExp | exc_pending;
  pc_next_sel #(.XLEN(XLEN), .EXC_VECTOR(EXC_VECTOR), .ALIGN_BITS(ALIGN_BITS)) u_sel (
    .eff_exc(eff_exc), .eret(IsEret & IsCOP0), .jr(IsJR), .jump(Jump),
    .br_taken(Branch & (BneOrBeq == Equal)), .instr_idx(Instr[25:0]), .ext(ExtendInst),
    .r1(RegfileR1), .epc(EPC), .pc_plus4(PCPlus4), .next_pc(next_pc),
    .target(target), .misaligned(misaligned)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      PCOut <= RESET_VECTOR;
      AddrExc <= 1'b0;
      BadVAddr <= '0;
      ExcPC <= '0;
      FetchCount <= '0;
      exc_pending <= 1'b0;
    end else begin
      state <= (state == BOOT || fire) ? RUN : HOLD;
      AddrExc <= fire & misaligned;
      // a short HasExp pulse must survive until the held fetch finally fires
      exc_pending <= fire ? 1'b0 : exc_pending | HasExp;
      if (fire) begin
        PCOut <= next_pc;
        FetchCount <= FetchCount + CNT_W'(1);
        if (eff_exc | misaligned) ExcPC <= PCOut;
        if (misaligned) BadVAddr <= target;
      end
    end
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation program-counter unit for the MIPS core.
- Holds the fetch PC and computes the next PC from exception, ERET, JR, jump, branch and sequential sources.
- Adds a valid/ready fetch handshake with stall, a sticky exception latch across held cycles, and misaligned-target detection with a BadVAddr capture.
- Adds a retired-fetch counter.
- Sits between the control/regfile/CP0 logic and the instruction memory port.

Parameters:
- XLEN, 32, address/data width.
- RESET_VECTOR, 32'h0040_0000, PC value after reset.
- EXC_VECTOR, 32'h8000_0180, exception handler entry.
- ALIGN_BITS, 2, low PC bits that must be zero (log2 of instruction bytes).
- CNT_W, 32, width of the retired-fetch counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- fetch_valid  out  1  PC is presented to instruction memory.
- fetch_ready  in  1  instruction memory accepts the PC.
- stall  in  1  core hold; blocks PC advance.
- HasExp  in  1  exception request (may be a 1-cycle pulse).
- IsEret  in  1  ERET instruction.
- IsCOP0  in  1  COP0 instruction; ERET is honoured only when IsEret&IsCOP0.
- IsJR  in  1  jump-register.
- Jump  in  1  J/JAL.
- Branch  in  1  conditional branch.
- BneOrBeq  in  1  1=BEQ, 0=BNE.
- Equal  in  1  comparator result.
- Instr  in  XLEN  current instruction.
- ExtendInst  in  XLEN  sign-extended immediate.
- RegfileR1  in  XLEN  JR target.
- EPC  in  XLEN  ERET target.
- PCOut  out  XLEN  current fetch PC.
- PCPlus4  out  XLEN  PCOut+4.
- AddrExc  out  1  1-cycle pulse: misaligned target trapped.
- BadVAddr  out  XLEN  last misaligned target.
- ExcPC  out  XLEN  PC of the instruction that trapped (EPC write value).
- Holding  out  1  FSM is in HOLD.
- FetchCount  out  CNT_W  number of accepted PC advances.

Behaviour:
- Reset (async, rst_n=0):
  - PCOut=RESET_VECTOR; state=BOOT; fetch_valid=0.
  - AddrExc=0, BadVAddr=0, ExcPC=0, FetchCount=0, exc_pending=0.
  - Reset asserted mid-HOLD discards the pending exception and any held redirect.
- FSM states:
  - BOOT: fetch_valid=0 for exactly one cycle after reset release, then -> RUN.
  - RUN: fetch_valid=1. fire = fetch_ready & ~stall.
    - fire: PC <= next_pc; stay in RUN.
    - no fire: PC held; -> HOLD.
  - HOLD: fetch_valid=1; PC held; Holding=1; on fire, PC <= next_pc and -> RUN.
- exc_pending:
  - Set when HasExp=1 while not firing.
  - Cleared on fire.
  - eff_exc = HasExp | exc_pending.
- next_pc priority, highest first:
  - eff_exc -> EXC_VECTOR.
  - IsEret&IsCOP0 -> EPC.
  - IsJR -> RegfileR1.
  - Jump -> {PCPlus4[XLEN-1:28], Instr[25:0], 2'b00}.
  - Branch & (BneOrBeq==Equal) -> PCPlus4 + (ExtendInst<<2).
  - otherwise -> PCPlus4.
- Arithmetic is modulo 2^XLEN; overflow wraps silently.
- Misalignment:
  - Applies when the selected target (EPC or RegfileR1 only) has nonzero [ALIGN_BITS-1:0] and eff_exc=0.
  - On fire: PC <= EXC_VECTOR, AddrExc=1 for one cycle, BadVAddr <= target, ExcPC <= PCOut.
  - No action until fire.
- On any fire with eff_exc=1: ExcPC <= PCOut.
- FetchCount increments by 1 per fire and wraps at 2^CNT_W.
- Simultaneous events:
  - HasExp with ERET/JR/Jump/Branch: exception wins.
  - stall=1 with fetch_ready=1: no advance.
- All outputs are registered except fetch_valid, Holding (state decode) and PCPlus4.

Decomposition:
- Shared package pc_pkg: FSM state enum (BOOT, RUN, HOLD), next-PC source select enum (SEL_EXC, SEL_ERET, SEL_JR, SEL_J, SEL_BR, SEL_SEQ), default vector constants.
- One combinational sub-module, pc_next_sel: priority select, target arithmetic and misalignment flag.
- Top level: FSM, PC register, exc_pending latch, capture registers and counter.

Test Plan:
- Reset then fetch_ready=1, all controls 0 -> BOOT cycle with fetch_valid=0; then PCOut 0x00400000 -> 0x00400004; FetchCount=1.
- At PC 0x00400004: Branch=1, BneOrBeq=1, Equal=1, ExtendInst=4 -> next PC 0x00400018. Repeat with Equal=0 -> 0x00400008.
- At PC 0x00400018: Jump=1, Instr=0x08000004 -> 0x00000010. IsJR=1, RegfileR1=0x10000000 -> 0x10000000. IsEret=IsCOP0=1, EPC=0x00001234 -> 0x00001234. IsEret=1, IsCOP0=0 -> sequential.
- IsJR=1, RegfileR1=0x10000002 at PC 0x00400020 -> PCOut 0x80000180, AddrExc pulses once, BadVAddr=0x10000002, ExcPC=0x00400020.
- fetch_ready=0 for 3 cycles with a 1-cycle HasExp pulse in the first cycle -> Holding=1, PCOut unchanged; on ready, PCOut=0x80000180 and FetchCount increments once.
- rst_n dropped asynchronously mid-HOLD with a pending exception -> immediate PCOut=0x00400000; after release, sequential fetch with no exception taken.
